// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the byte-serial RAM initiator.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Encoding 2'b11 is deliberately folded into the word case.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_assembler.sv
// Collects load bytes into lanes and presents the zero/sign-extended result,
// including the byte being captured this cycle.
module mem_byte_assembler
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        clear,
    input  logic        capture,
    input  logic [1:0]  lane,
    input  logic [7:0]  byte_data,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [31:0] data_reg;
    logic [31:0] merged;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = (capture && lane == 2'(gi)) ? byte_data
                                                                    : data_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            data_reg <= '0;
        end else if (capture) begin
            data_reg <= merged;
        end
    end

    always_comb begin
        result = merged;
        case (size)
            SIZE_BYTE: result = {{24{sign_ext & merged[7]}}, merged[7:0]};
            SIZE_HALF: result = {{16{sign_ext & merged[15]}}, merged[15:0]};
            default:   result = merged;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial initiator: one 1/2/4-byte access at a time, issued little-endian
// to an 8-bit synchronous RAM, with a one-cycle response pulse.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic                  req_we_in,
    input  logic [1:0]            req_size_in,
    input  logic                  req_signed_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic [31:0]           req_wdata_in,
    output logic                  resp_valid_out,
    output logic [31:0]           resp_rdata_out,
    output logic                  ram_en_out,
    output logic                  ram_r_nw_out,
    output logic [ADDR_WIDTH-1:0] ram_a_out,
    output logic [7:0]            ram_d_out,
    input  logic [7:0]            ram_d_in
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_reg;
    logic [1:0]            k_reg;
    logic [1:0]            last_k_reg;
    logic                  we_reg;
    logic [1:0]            size_reg;
    logic                  signed_reg;
    logic [31:0]           wdata_reg;
    logic                  cap_pending_reg;
    logic [1:0]            cap_lane_reg;
    logic                  resp_valid_reg;
    logic [31:0]           resp_rdata_reg;
    logic                  ram_en_reg;
    logic                  ram_r_nw_reg;
    logic [ADDR_WIDTH-1:0] ram_a_reg;
    logic [7:0]            ram_d_reg;

    logic                  accept;
    logic [1:0]            k_inc;
    logic [31:0]           asm_result;

    assign req_ready_out = (state_reg == IDLE);
    assign accept        = req_valid_in && req_ready_out;
    assign k_inc         = k_reg + 2'd1;

    assign resp_valid_out = resp_valid_reg;
    assign resp_rdata_out = resp_rdata_reg;
    assign ram_en_out     = ram_en_reg;
    assign ram_r_nw_out   = ram_r_nw_reg;
    assign ram_a_out      = ram_a_reg;
    assign ram_d_out      = ram_d_reg;

    // The RAM returns a read byte one cycle after it is addressed, so the
    // capture lane trails the issue counter by one cycle.
    mem_byte_assembler u_asm (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear     (accept),
        .capture   (cap_pending_reg),
        .lane      (cap_lane_reg),
        .byte_data (ram_d_in),
        .size      (size_reg),
        .sign_ext  (signed_reg),
        .result    (asm_result)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg       <= IDLE;
            k_reg           <= '0;
            last_k_reg      <= '0;
            we_reg          <= 1'b0;
            size_reg        <= SIZE_BYTE;
            signed_reg      <= 1'b0;
            wdata_reg       <= '0;
            cap_pending_reg <= 1'b0;
            cap_lane_reg    <= '0;
            resp_valid_reg  <= 1'b0;
            resp_rdata_reg  <= '0;
            ram_en_reg      <= 1'b0;
            ram_r_nw_reg    <= 1'b1;
            ram_a_reg       <= '0;
            ram_d_reg       <= '0;
        end else begin
            cap_pending_reg <= 1'b0;
            resp_valid_reg  <= 1'b0;
            resp_rdata_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (req_valid_in) begin
                        we_reg       <= req_we_in;
                        size_reg     <= req_size_in;
                        signed_reg   <= req_signed_in;
                        wdata_reg    <= req_wdata_in;
                        last_k_reg   <= 2'(size_to_nbytes(req_size_in) - 3'd1);
                        k_reg        <= '0;
                        ram_en_reg   <= 1'b1;
                        ram_r_nw_reg <= ~req_we_in;
                        ram_a_reg    <= req_addr_in;
                        ram_d_reg    <= req_we_in ? req_wdata_in[7:0] : 8'h00;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cap_pending_reg <= ~we_reg;
                    cap_lane_reg    <= k_reg;
                    if (k_reg == last_k_reg) begin
                        ram_r_nw_reg <= 1'b1;
                        ram_d_reg    <= 8'h00;
                        if (we_reg) begin
                            ram_en_reg     <= 1'b0;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= RESP;
                        end else begin
                            // Enable stays high: the RAM zeroes its output when disabled.
                            state_reg <= DRAIN;
                        end
                    end else begin
                        k_reg     <= k_inc;
                        ram_a_reg <= ram_a_reg + ADDR_ONE;
                        ram_d_reg <= we_reg ? wdata_reg[{k_inc, 3'b000} +: 8] : 8'h00;
                    end
                end
                DRAIN: begin
                    ram_en_reg     <= 1'b0;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= asm_result;
                    state_reg      <= RESP;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table of accesses, RAM model,
// and queues of expected RAM cycles and responses.
module tb_mem_ctrl;

    localparam int AW = 17;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          req_valid_in = 1'b0;
    logic          req_ready_out;
    logic          req_we_in = 1'b0;
    logic [1:0]    req_size_in = 2'b00;
    logic          req_signed_in = 1'b0;
    logic [AW-1:0] req_addr_in = '0;
    logic [31:0]   req_wdata_in = '0;
    logic          resp_valid_out;
    logic [31:0]   resp_rdata_out;
    logic          ram_en_out;
    logic          ram_r_nw_out;
    logic [AW-1:0] ram_a_out;
    logic [7:0]    ram_d_out;
    logic [7:0]    ram_d_in;

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_we_in      (req_we_in),
        .req_size_in    (req_size_in),
        .req_signed_in  (req_signed_in),
        .req_addr_in    (req_addr_in),
        .req_wdata_in   (req_wdata_in),
        .resp_valid_out (resp_valid_out),
        .resp_rdata_out (resp_rdata_out),
        .ram_en_out     (ram_en_out),
        .ram_r_nw_out   (ram_r_nw_out),
        .ram_a_out      (ram_a_out),
        .ram_d_out      (ram_d_out),
        .ram_d_in       (ram_d_in)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // 8-bit synchronous RAM model: registered read, output gated by enable.
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] ram_q = 8'h00;
    always @(posedge clk_in) begin
        if (ram_en_out) begin
            if (!ram_r_nw_out) mem[ram_a_out] <= ram_d_out;
            else               ram_q <= mem[ram_a_out];
        end
    end
    assign ram_d_in = ram_en_out ? ram_q : 8'h00;

    typedef struct {
        logic          r_nw;
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            c;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        int          c;
    } rsp_t;

    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic          sgn;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp;
    } vec_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Expected RAM cycles and response for a request accepted at the end of cycle a_cyc.
    task automatic push_expect(input logic we, input logic [1:0] size, input logic [AW-1:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp, input int a_cyc);
        int n;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++)
            acc_q.push_back('{~we, AW'(addr + AW'(k)), we ? wdata[8*k +: 8] : 8'h00, a_cyc + 1 + k});
        if (!we) begin
            acc_q.push_back('{1'b1, AW'(addr + AW'(n - 1)), 8'h00, a_cyc + n + 1});
            rsp_q.push_back('{exp, a_cyc + n + 2});
        end else begin
            rsp_q.push_back('{32'h0, a_cyc + n + 1});
        end
    endtask

    always @(negedge clk_in) begin
        if (mon_en && !rst_in) begin
            check("ready_vs_busy", 32'(req_ready_out), 32'(rsp_q.size() == 0));
            if (ram_en_out) begin
                if (acc_q.size() == 0) begin
                    fail_now("unexpected_ram_access");
                end else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    check("ram_r_nw", 32'(ram_r_nw_out), 32'(e.r_nw));
                    check("ram_addr", 32'(ram_a_out), 32'(e.a));
                    check("ram_wdata", 32'(ram_d_out), 32'(e.d));
                    check("ram_cycle", 32'(cyc), 32'(e.c));
                end
            end else begin
                check("idle_r_nw", 32'(ram_r_nw_out), 32'd1);
                check("idle_d", 32'(ram_d_out), 32'd0);
            end
            if (resp_valid_out) begin
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("resp_rdata", resp_rdata_out, r.rdata);
                    check("resp_cycle", 32'(cyc), 32'(r.c));
                    $display("resp at cycle %0d rdata=%h", cyc, resp_rdata_out);
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (rsp_q.size() != 0 && t < 20) begin
            @(negedge clk_in); #1;
            t++;
        end
        if (rsp_q.size() != 0) begin
            fail_now("resp_timeout");
            rsp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic do_req(input vec_t v);
        int t = 0;
        @(negedge clk_in); #1;
        while (!req_ready_out && t < 20) begin
            @(negedge clk_in); #1;
            t++;
        end
        if (!req_ready_out) fail_now("ready_timeout");
        req_we_in     = v.we;
        req_size_in   = v.size;
        req_signed_in = v.sgn;
        req_addr_in   = v.addr;
        req_wdata_in  = v.wdata;
        req_valid_in  = 1'b1;
        push_expect(v.we, v.size, v.addr, v.wdata, v.exp, cyc);
        $display("req we=%0d size=%0d sgn=%0d addr=%h wdata=%h exp=%h", v.we, v.size, v.sgn,
                 v.addr, v.wdata, v.exp);
        @(negedge clk_in); #1;
        req_valid_in = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_cyc;
        int b_cyc;
        vec_t v;

        //                 we    size   sgn   addr        wdata         expected
        vecs.push_back('{1'b1, 2'd2, 1'b0, 17'h00100, 32'hDEADBEEF, 32'h00000000});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 17'h00100, 32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 17'h00200, 32'h00123480, 32'h00000000});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 17'h00200, 32'h0,        32'hFFFFFF80});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 17'h00200, 32'h0,        32'h00000080});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 17'h00201, 32'h0,        32'h00001234});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 17'h00201, 32'h0,        32'h00001234});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 17'h00204, 32'h55667788, 32'h00000000});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 17'h00204, 32'hFFFF9ABC, 32'h00000000});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 17'h00204, 32'h0,        32'h55669ABC});
        vecs.push_back('{1'b1, 2'd0, 1'b1, 17'h00207, 32'h123456F0, 32'h00000000});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 17'h00204, 32'h0,        32'hF0669ABC});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 17'h00204, 32'h0,        32'hFFFF9ABC});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 17'h00205, 32'h0,        32'hFFFFFF9A});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 17'h00202, 32'h0,        32'h9ABC0012});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 17'h1FFFF, 32'h11223344, 32'h00000000});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 17'h1FFFF, 32'h0,        32'h11223344});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 17'h1FFFF, 32'h0,        32'h00003344});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 17'h00000, 32'h0,        32'h00000033});
        vecs.push_back('{1'b1, 2'd3, 1'b0, 17'h00300, 32'hCAFEF00D, 32'h00000000});
        vecs.push_back('{1'b0, 2'd3, 1'b1, 17'h00300, 32'h0,        32'hCAFEF00D});
        vecs.push_back('{1'b0, 2'd2, 1'b1, 17'h00100, 32'h0,        32'hDEADBEEF});

        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in); #1;
        check("rst_ready", 32'(req_ready_out), 32'd1);
        check("rst_resp_valid", 32'(resp_valid_out), 32'd0);
        check("rst_rdata", resp_rdata_out, 32'd0);
        check("rst_ram_en", 32'(ram_en_out), 32'd0);
        check("rst_ram_r_nw", 32'(ram_r_nw_out), 32'd1);
        check("rst_ram_a", 32'(ram_a_out), 32'd0);
        check("rst_ram_d", 32'(ram_d_out), 32'd0);
        mon_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);

        check("mem_100", 32'(mem[17'h00100]), 32'hEF);
        check("mem_101", 32'(mem[17'h00101]), 32'hBE);
        check("mem_102", 32'(mem[17'h00102]), 32'hAD);
        check("mem_103", 32'(mem[17'h00103]), 32'hDE);
        check("mem_1ffff", 32'(mem[17'h1FFFF]), 32'h44);
        check("mem_00000", 32'(mem[17'h00000]), 32'h33);
        check("mem_00001", 32'(mem[17'h00001]), 32'h22);
        check("mem_00002", 32'(mem[17'h00002]), 32'h11);

        // Back-to-back: valid held high, second load must be taken right after RESP.
        @(negedge clk_in); #1;
        a_cyc = cyc;
        req_we_in = 1'b0; req_size_in = 2'd2; req_signed_in = 1'b0;
        req_addr_in = 17'h00100; req_wdata_in = 32'h0; req_valid_in = 1'b1;
        push_expect(1'b0, 2'd2, 17'h00100, 32'h0, 32'hDEADBEEF, a_cyc);
        $display("req b2b first load word addr=00100 at cycle %0d", a_cyc);
        @(negedge clk_in); #1;
        req_size_in = 2'd1; req_addr_in = 17'h00204;
        b_cyc = a_cyc + 4 + 3;
        while (cyc < b_cyc) begin
            @(negedge clk_in); #1;
        end
        push_expect(1'b0, 2'd1, 17'h00204, 32'h0, 32'h00009ABC, b_cyc);
        $display("req b2b second load half addr=00204 expected accept cycle %0d", b_cyc);
        @(negedge clk_in); #1;
        req_valid_in = 1'b0;
        wait_idle();

        // Reset during a word store: only bytes 0 and 1 reach the RAM.
        v = '{1'b1, 2'd2, 1'b0, 17'h00310, 32'h00000000, 32'h0};
        do_req(v);
        @(negedge clk_in); #1;
        a_cyc = cyc;
        req_we_in = 1'b1; req_size_in = 2'd2; req_signed_in = 1'b0;
        req_addr_in = 17'h00310; req_wdata_in = 32'hA1B2C3D4; req_valid_in = 1'b1;
        push_expect(1'b1, 2'd2, 17'h00310, 32'hA1B2C3D4, 32'h0, a_cyc);
        $display("req store word addr=00310 wdata=A1B2C3D4 with reset at cycle %0d", a_cyc + 2);
        @(negedge clk_in); #1;
        req_valid_in = 1'b0;
        @(negedge clk_in); #1;
        rst_in = 1'b1;
        acc_q.delete();
        rsp_q.delete();
        @(negedge clk_in); #1;
        check("midrst_ram_en", 32'(ram_en_out), 32'd0);
        check("midrst_ready", 32'(req_ready_out), 32'd1);
        check("midrst_resp_valid", 32'(resp_valid_out), 32'd0);
        rst_in = 1'b0;
        repeat (6) @(negedge clk_in);
        #1;
        check("midrst_mem_310", 32'(mem[17'h00310]), 32'hD4);
        check("midrst_mem_311", 32'(mem[17'h00311]), 32'hC3);
        check("midrst_mem_312", 32'(mem[17'h00312]), 32'h00);
        check("midrst_mem_313", 32'(mem[17'h00313]), 32'h00);
        v = '{1'b0, 2'd2, 1'b0, 17'h00310, 32'h0, 32'h0000C3D4};
        do_req(v);

        repeat (3) @(negedge clk_in);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory initiator between the CPU load/store path and the 8-bit synchronous on-board RAM. It accepts one 1/2/4-byte access at a time over a valid/ready request port. It issues the byte accesses to the RAM little-endian, one per cycle, and assembles or scatters the 32-bit data. It returns a one-cycle response pulse, with zero/sign extension applied on narrow reads.

## Interface
- ADDR_WIDTH, 17: RAM address width; byte addresses wrap modulo 2^ADDR_WIDTH.
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- req_valid_in  in  1  access request present.
- req_ready_out  out  1  controller can accept a request (high only in IDLE).
- req_we_in  in  1  1 = store, 0 = load.
- req_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_signed_in  in  1  sign-extend narrow loads; ignored for word loads and all stores.
- req_addr_in  in  ADDR_WIDTH  byte address of lowest byte; misalignment permitted.
- req_wdata_in  in  32  store data; bits [8N-1:0] used.
- resp_valid_out  out  1  one-cycle completion pulse.
- resp_rdata_out  out  32  load result, valid while resp_valid_out; 0 for stores.
- ram_en_out  out  1  RAM chip enable.
- ram_r_nw_out  out  1  RAM read (1) / write (0).
- ram_a_out  out  ADDR_WIDTH  RAM byte address.
- ram_d_out  out  8  RAM write data.
- ram_d_in  in  8  RAM read data; registered inside the RAM, forced to 0 by the RAM when en is low.

## Operation
- N = 1, 2 or 4 bytes from req_size_in.
- Handshake: the request is accepted on the clock edge where req_valid_in && req_ready_out. All request fields are latched at acceptance. Inputs are ignored outside IDLE.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
  - IDLE -> ISSUE on accept; byte counter k = 0.
  - ISSUE: drive ram_en_out=1, ram_a_out = base+k (mod 2^ADDR_WIDTH), ram_r_nw_out = ~we. For stores, ram_d_out = wdata[8k+7:8k]. Increment k. After byte N-1: stores go to RESP, loads go to DRAIN.
  - DRAIN (loads only, 1 cycle): hold ram_en_out=1, ram_r_nw_out=1, address = last byte. En must stay high because the RAM gates its data output with en.
  - RESP: resp_valid_out=1 for one cycle; ram_en_out=0; next state IDLE.
- Load capture: the byte for address base+k appears on ram_d_in in the cycle after it is issued. It is written into rdata[8k+7:8k] at the end of that cycle.
- Extension: byte result = {24{signed & b7}, b}; half result = {16{signed & h15}, h}; word result is unmodified.
- ram_r_nw_out = 1 and ram_d_out = 0 whenever not writing. No RAM write ever occurs outside ISSUE with we=1.
- Reset (any state): state IDLE, k=0, req_ready_out=1 from the first cycle after reset, resp_valid_out=0, resp_rdata_out=0, ram_en_out=0, ram_r_nw_out=1, ram_a_out=0, ram_d_out=0. An in-flight access is abandoned without a response; store bytes already issued remain written.

## Timing
- All outputs are registered except req_ready_out, which is decoded from state.
- Acceptance at edge ending cycle A:
  - RAM access cycles: A+1 … A+N.
  - Load: byte k is captured at the end of cycle A+2+k. resp_valid_out is high in cycle A+N+2. Latency N+2: word 6, half 4, byte 3.
  - Store: resp_valid_out is high in cycle A+N+1. Latency N+1.
- Earliest next acceptance is the cycle after RESP (cycle A+N+3 for loads, A+N+2 for stores). Requests are never pipelined or overlapped.
- Address wrap: base = 2^ADDR_WIDTH-1 with a word access issues addresses 1FFFF, 00000, 00001, 00002 (ADDR_WIDTH=17).

## Structure
- Package mem_ctrl_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state enum IDLE/ISSUE/DRAIN/RESP;
  - function size_to_nbytes.
- One natural sub-module, mem_byte_assembler. It is purely combinational plus one register. It takes the captured byte, lane k and a clear, and produces the extended 32-bit result. The FSM, counter and RAM drive stay in mem_ctrl.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x00100 -> RAM bytes 0x100..0x103 = EF BE AD DE; resp after 5 cycles. Word load at 0x00100 -> rdata 0xDEADBEEF with resp_valid_out in cycle A+6.
- Signed/unsigned byte: RAM[0x200]=0x80. LB -> 0xFFFFFF80; LBU -> 0x00000080. Half at 0x201 with bytes 0x34,0x12 gives LH 0x00001234.
- Misaligned and wrap: word store 0x11223344 at 0x1FFFF -> RAM[0x1FFFF]=44, RAM[0x0]=33, RAM[0x1]=22, RAM[0x2]=11. Word load at the same address returns 0x11223344.
- Back-to-back: req_valid_in held high with two loads -> second accepted exactly the cycle after the first resp_valid_out; req_ready_out low throughout the first access.
- Reset mid-access: assert rst_in in cycle A+2 of a word store -> next cycle ram_en_out=0, req_ready_out=1, no resp_valid_out; only bytes 0–1 written.
- Size 11: behaves identically to word (4 RAM accesses, 32-bit result).
